bus_interconnect: RTL

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

---
 rtl/bus_interconnect.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bus_interconnect.sv
// bus_interconnect: single master to NUM_SLAVES slaves with address decode,
// alignment checking and a one-cycle completion pulse back to the master.
// Optional feature: define BUS_INTERCONNECT_TIMEOUT_EN to abort an access when
// the selected slave has not answered within TIMEOUT wait cycles.
module bus_interconnect #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 28,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     m_valid,
    input  logic                     m_write,
    input  logic [1:0]               m_size,
    input  logic [31:0]              m_address,
    input  logic [31:0]              m_wdata,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,
    output logic                     m_response,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic                     s_write,
    output logic [1:0]               s_size,
    output logic [31:0]              s_address,
    output logic [31:0]              s_wdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_error
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
        $error("bus_interconnect: NUM_SLAVES must be in 1..8");
    end
    if (SEL_LSB < 0 || SEL_LSB > 29) begin : g_bad_sel_lsb
        $error("bus_interconnect: SEL_LSB must leave room for a 3-bit index");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_interconnect: TIMEOUT must be in 1..65535");
    end

    localparam logic [3:0] SLAVE_COUNT = 4'(NUM_SLAVES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              index;
    logic                    decode_error;
    logic [NUM_SLAVES-1:0]   select;
    logic                    sel_ready;
    logic                    sel_error;
    logic [31:0]             sel_rdata;
    logic                    timed_out;

    // Decode the slave index and flag out-of-range or misaligned requests.
    always_comb begin
        index        = m_address[SEL_LSB+2:SEL_LSB];
        decode_error = 1'b0;
        if ({1'b0, index} >= SLAVE_COUNT) begin
            decode_error = 1'b1;
        end
        if (m_size == 2'b11) begin
            decode_error = 1'b1;
        end
        if (m_size == 2'b01 && m_address[0]) begin
            decode_error = 1'b1;
        end
        if (m_size == 2'b10 && m_address[1:0] != 2'b00) begin
            decode_error = 1'b1;
        end
        select = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            select[i] = (index == 3'(i));
        end
    end

    // Pick the response of the slave currently selected; s_valid is one-hot so
    // non-selected ports cannot contribute.
    always_comb begin
        sel_ready = |(s_ready & s_valid);
        sel_error = |(s_error & s_valid);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_valid[i]) begin
                sel_rdata = sel_rdata | s_rdata[32*i +: 32];
            end
        end
    end

`ifdef BUS_INTERCONNECT_TIMEOUT_EN
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    logic [15:0] counter;

    // Count wait cycles of the current access; cleared when an access starts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter <= '0;
        end else if (state == IDLE && m_valid && !decode_error) begin
            counter <= '0;
        end else if (state == ACCESS && !sel_ready) begin
            counter <= counter + 16'd1;
        end
    end

    assign timed_out = (counter == LAST_WAIT);
`else
    assign timed_out = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m_valid) begin
                    state_next = decode_error ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (sel_ready || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, slave select and captured response data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_valid    <= '0;
            s_write    <= 1'b0;
            s_size     <= 2'b00;
            s_address  <= '0;
            s_wdata    <= '0;
            m_rdata    <= '0;
            m_response <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        s_write   <= m_write;
                        s_size    <= m_size;
                        s_address <= m_address;
                        s_wdata   <= m_wdata;
                        if (decode_error) begin
                            s_valid    <= '0;
                            m_rdata    <= '0;
                            m_response <= 1'b1;
                        end else begin
                            s_valid <= select;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        s_valid    <= '0;
                        m_rdata    <= s_write ? 32'd0 : sel_rdata;
                        m_response <= sel_error;
                    end else if (timed_out) begin
                        s_valid    <= '0;
                        m_rdata    <= '0;
                        m_response <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_ready = (state == RESP);

endmodule
